// File: rtl/demux_ctrl_pkg.sv
// Shared types and constants for the 1-to-4 dispatch controller.
package demux_ctrl_pkg;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned SEL_W  = 2;

    typedef logic [SEL_W-1:0] ch_sel_t;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } dispatch_state_t;

    // Advances a round-robin pointer, wrapping 3 back to 0.
    function automatic ch_sel_t rr_next(input ch_sel_t ptr);
        return ptr + SEL_W'(1);
    endfunction

endpackage

// File: rtl/onehot_dec.sv
// 2-to-4 one-hot decoder with enable; all outputs zero when disabled.
module onehot_dec
    import demux_ctrl_pkg::*;
(
    input  ch_sel_t           i_sel,
    input  logic              i_en,
    output logic [NUM_CH-1:0] o_onehot_c
);

    always_comb begin
        o_onehot_c = '0;
        if (i_en) begin
            o_onehot_c[i_sel] = 1'b1;
        end
    end

endmodule

// File: rtl/demux_dispatch_ctrl.sv
// Single-item dispatch controller routing a valid/ready stream to one of four channels.
// Optional per-channel saturating delivery counters under DISPATCH_STATS_EN.
module demux_dispatch_ctrl
    import demux_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W = 8
`ifdef DISPATCH_STATS_EN
    ,
    parameter int unsigned CNT_W  = 16
`endif
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [DATA_W-1:0]       in_data,
    input  ch_sel_t                 in_dest,
    input  logic                    rr_mode,
    output logic [NUM_CH-1:0]       out_valid,
    output logic [DATA_W-1:0]       out_data,
    input  logic [NUM_CH-1:0]       out_ready,
    output logic                    busy
`ifdef DISPATCH_STATS_EN
    ,
    output logic [NUM_CH*CNT_W-1:0] ch_count
`endif
);

    dispatch_state_t    r_state;
    dispatch_state_t    w_state_nxt;
    ch_sel_t            r_sel;
    ch_sel_t            w_sel_nxt;
    ch_sel_t            r_rr_ptr;
    ch_sel_t            w_rr_ptr_nxt;
    logic               r_mode;
    logic               w_mode_nxt;
    logic               w_eff_mode;
    logic [DATA_W-1:0]  r_data;
    logic [DATA_W-1:0]  w_data_nxt;
    logic               w_hold;
    logic               w_in_fire;
    logic               w_out_fire;
    logic [NUM_CH-1:0]  w_valid;

    assign w_hold     = (r_state == HOLD);
    assign in_ready   = !w_hold || out_ready[r_sel];
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = w_hold && out_ready[r_sel];

    // Mode is taken live when leaving IDLE, otherwise the latched value applies.
    assign w_eff_mode = w_hold ? r_mode : rr_mode;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_sel    <= '0;
            r_rr_ptr <= '0;
            r_mode   <= 1'b0;
            r_data   <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_sel    <= w_sel_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
            r_mode   <= w_mode_nxt;
            r_data   <= w_data_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_sel_nxt    = r_sel;
        w_rr_ptr_nxt = r_rr_ptr;
        w_mode_nxt   = r_mode;
        w_data_nxt   = r_data;
        case (r_state)
            IDLE: begin
                if (w_in_fire) begin
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (w_out_fire && !w_in_fire) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        // A capture (from IDLE or as a pass-through reload) loads item and channel.
        if (w_in_fire) begin
            w_data_nxt = in_data;
            w_mode_nxt = w_eff_mode;
            if (w_eff_mode) begin
                w_sel_nxt    = r_rr_ptr;
                w_rr_ptr_nxt = rr_next(r_rr_ptr);
            end else begin
                w_sel_nxt    = in_dest;
            end
        end
    end

    onehot_dec u_onehot_dec (
        .i_sel      (r_sel),
        .i_en       (w_hold),
        .o_onehot_c (w_valid)
    );

    assign out_valid = w_valid;
    assign out_data  = r_data;
    assign busy      = w_hold;

`ifdef DISPATCH_STATS_EN
    logic [CNT_W-1:0]  r_cnt [NUM_CH];
    logic [NUM_CH-1:0] w_ch_fire;

    assign w_ch_fire = w_valid & out_ready;

    // Per-channel delivery counters that stick at all-ones.
    for (genvar k = 0; k < NUM_CH; k++) begin : g_cnt
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt[k] <= '0;
            end else if (w_ch_fire[k] && (r_cnt[k] != {CNT_W{1'b1}})) begin
                r_cnt[k] <= r_cnt[k] + CNT_W'(1);
            end
        end
        assign ch_count[k*CNT_W +: CNT_W] = r_cnt[k];
    end
`endif

endmodule

// File: doc/demux_dispatch_ctrl.md
# demux_dispatch_ctrl

Sequencing controller for the 1-to-4 demultiplexer datapath. It accepts a stream of data items on a valid/ready input. It registers each item and routes it to exactly one of four output channels, either by an explicit destination field or by a round-robin schedule. It sits between a single producer and four consumers, and guarantees one-hot, handshake-safe delivery.

## Interface
Parameters:
- `DATA_W`, default 8: width of each data item.
- `CNT_W`, default 16: width of the per-channel delivery counters (only with `DISPATCH_STATS_EN`).

Ports:
- `clk`  in  1  single clock. All flops are rising-edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  producer has an item.
- `in_ready`  out  1  controller can take an item this cycle.
- `in_data`  in  `DATA_W`  item payload.
- `in_dest`  in  2  destination channel, used in addressed mode.
- `rr_mode`  in  1  0 = addressed, 1 = round-robin. Sampled only in IDLE.
- `out_valid`  out  4  one-hot or zero. Bit k means channel k holds an item.
- `out_data`  out  `DATA_W`  payload shared by all channels. Meaningful only while any `out_valid` bit is set.
- `out_ready`  in  4  per-channel consumer ready.
- `busy`  out  1  high while an item is held.
- `ch_count`  out  4×`CNT_W`  delivered-item count per channel (only with `DISPATCH_STATS_EN`).

## Operation
- State machine with two states:
  - IDLE: no item held.
  - HOLD: one item held in the output register, with its channel index `sel[1:0]`.
- Input handshake: an item is captured when `in_valid && in_ready`. This is the input transfer.
- `in_ready` = (state==IDLE) || (state==HOLD && out_ready[sel]). This makes the path pass-through with full throughput of one item per cycle.
- Output handshake: an item is delivered when `out_valid[sel] && out_ready[sel]`. This is the output transfer.
- Channel selection on capture:
  - addressed mode: `sel` = `in_dest`.
  - round-robin mode: `sel` = `rr_ptr`.
- Round-robin pointer:
  - `rr_ptr` increments modulo 4 on each captured item in round-robin mode (3 wraps to 0).
  - It is unchanged in addressed mode.
- Mode latch: `rr_mode` is latched only on transitions out of IDLE. Toggling it while in HOLD has no effect until the controller next leaves IDLE.
- Transitions:
  - IDLE→HOLD on input transfer.
  - HOLD→IDLE on output transfer without an input transfer.
  - HOLD→HOLD, loading a new item, on a simultaneous output and input transfer in the same cycle.
  - HOLD→HOLD, holding the item, while `out_ready[sel]`=0.
- Stability: while in HOLD with no output transfer, `out_valid`, `out_data` and `sel` stay stable.
- Isolation: `out_ready` on non-selected channels is ignored.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `busy`=0, `in_ready`=1, `rr_ptr`=0, state=IDLE, `ch_count`=0.
- Reset is asynchronous. Assertion mid-HOLD discards the held item immediately, with no delivery.
- Latency: an input transfer in cycle n gives `out_valid[sel]`=1 in cycle n+1.
- `out_valid` is a registered output. It never depends combinationally on `out_ready`.
- `in_ready` depends combinationally on `out_ready[sel]`. This is the only combinational path.
- Back-to-back operation: with `out_ready` all 1, sustained throughput is one item per cycle and `out_valid` never drops between items.
- Round-robin sequence from reset: channels 0,1,2,3,0,…

## Configuration
- `DISPATCH_STATS_EN` defined:
  - Adds `ch_count` and four saturating counters of `CNT_W` bits.
  - Counter k increments on each output transfer on channel k.
  - A counter holds at all-ones once saturated.
- Not defined: no counters and no `ch_count` port. Behaviour is otherwise identical.

## Structure
- Package `demux_ctrl_pkg` holds:
  - state enum `dispatch_state_t` {IDLE, HOLD}.
  - constant `NUM_CH`=4.
  - typedef `ch_sel_t` = logic[1:0].
- Sub-module `onehot_dec`: 2-to-4 decoder with enable. It produces `out_valid` from `sel` gated by state==HOLD. It is instantiated once.

## Test plan
- Reset behaviour: assert `rst_n`=0 mid-HOLD holding 0xA5 → outputs return to their reset values that cycle, and 0xA5 is never delivered.
- Addressed routing: send 0x11,0x22,0x33,0x44 with `in_dest` 3,0,2,1 and all ready → `out_valid` is 1000,0001,0100,0010 on consecutive cycles, with data in order.
- Round-robin wrap: `rr_mode`=1, send six items 0x01–0x06 → channels 0,1,2,3,0,1, with throughput one per cycle.
- Back-pressure: `out_ready`[2]=0 for 5 cycles with an item for channel 2 held → `out_valid`=0100 and `out_data` stay stable, `in_ready`=0. On release, delivery occurs in the same cycle and the next item loads.
- Isolation: selected channel not ready, other `out_ready` bits all 1 → no delivery and no state change.
- With `DISPATCH_STATS_EN` and `CNT_W`=2: deliver five items to channel 1 → `ch_count[1]`=3 (saturated), other counters 0.
